sev_seg_capture: RTL and testbench
==================================

# sev_seg_capture

- Reads the six active-low seven-segment digit buses produced by the add/sub display path and recovers the three signed 4-bit operands/result (A, B, S).
- Inputs must be stable for a configurable number of cycles before capture.
- Captured values are presented with a Valid/Ready handshake and a per-pair illegal-pattern flag.
- Sits on the board-level loopback/self-test path, as the decode-side counterpart of the display encoder.

## Interface
- STABLE_CYCLES, 4: consecutive unchanged samples required before capture; legal range ≥1.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- Hex5, Hex4  in  7 each  A sign/digit pair, active-low, bit6=g … bit0=a.
- Hex3, Hex2  in  7 each  B pair.
- Hex1, Hex0  in  7 each  S pair.
- AddSub  in  1  operation shown on the display (0 add, 1 subtract); used only with SEV_SELFCHECK_EN.
- Ready  in  1  consumer accepts the captured set.
- A, B, S  out  4 each  decoded two's-complement values.
- Valid  out  1  captured set available.
- Err  out  1  at least one pair illegal.
- ErrMask  out  3  illegal pair flags: bit2=A, bit1=B, bit0=S.
- Mismatch  out  1  self-check failure.
- Ovr  out  1  signed overflow of the displayed operation.

## Operation
- Pair decode (left digit, right digit):
  - Left 1111111 (blank) with right 1000000/1111001/0100100/0110000/0011001/0010010/0000010/1111000 → 0..7.
  - Left 0111111 (minus) with right glyph for 8/7/6/5/4/3/2/1 → 1000..1111. The glyph for 8 is 0000000.
  - Anything else is illegal: blank with 8, minus with 0, any other left or right pattern. The pair value is 0000 and its ErrMask bit is 1.
- Every cycle, all 42 Hex bits plus AddSub are registered into HexQ, and HexQ is copied into HexPrev.
- Stability counter Cnt, width $clog2(STABLE_CYCLES+1):
  - Cleared when HexQ≠HexPrev.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM states SETTLE, HOLD, WAIT_CHANGE:
  - SETTLE: when Cnt==STABLE_CYCLES, decode HexQ into A/B/S/Err/ErrMask, store HexQ in Snap, set Valid, go to HOLD.
  - HOLD: Valid and all data outputs frozen; Hex changes are ignored. When Ready=1 at an edge, clear Valid and go to WAIT_CHANGE.
  - WAIT_CHANGE: when HexQ≠Snap, go to SETTLE. Cnt keeps running throughout, so a return to the old pattern is re-captured as a new set.
- Ready is ignored outside HOLD. Valid never drops without Ready or Reset.
- Err = |ErrMask, updated only at capture.

## Timing
- Reset values: state SETTLE; HexQ and HexPrev all-ones; Snap all-ones; Cnt 0; A, B, S 0; Valid, Err, Mismatch, Ovr 0; ErrMask 000.
- Capture latency: if a new pattern is first sampled at edge k and then held, Valid=1 after edge k+STABLE_CYCLES+2.
- Any change before capture restarts the count.
- Handshake: Valid&Ready sampled at edge m gives Valid=0 after edge m. The earliest next capture is STABLE_CYCLES+2 edges after a change is sampled in WAIT_CHANGE.
- Reset asserted in any state, including HOLD with Valid=1: all reset values hold after that edge; the pending set is discarded.
- No combinational path from inputs to outputs.

## Configuration
- SEV_SELFCHECK_EN defined, evaluated in the capture cycle:
  - Compute E = A + (B ^ {4{AddSub}}) + AddSub, mod 16, using the captured AddSub.
  - Mismatch = (E≠S).
  - Ovr = signed overflow of that operation.
  - Both are forced to 0 when Err=1.
  - Both are frozen with the other outputs.
- SEV_SELFCHECK_EN undefined: AddSub is unused; Mismatch and Ovr are tied to 0; no adder logic is generated.

## Structure
- Package sev_pkg:
  - Segment glyph constants for 0–8.
  - SEG_BLANK and SEG_MINUS.
  - FSM state enum.
  - ErrMask bit indices.
- Sub-module sev_pair_decode: combinational, (left[6:0], right[6:0]) → (value[3:0], illegal). Instantiated three times.

## Test plan
- Reset, then A=blank/3, B=minus/2, S=blank/1 held, STABLE_CYCLES=4 → Valid=1 after 6 edges; A=0011, B=1110, S=0001; Err=0, ErrMask=000.
- Hex0 toggling every 2 cycles for 12 cycles, then held → Valid stays 0 during toggling and rises 6 edges after the final change is sampled.
- Hex1/Hex0 = minus/"0" (0111111/1000000), other pairs legal → Valid=1, Err=1, ErrMask=001, S=0000.
- Ready low for 20 cycles with Hex changing → Valid and outputs unchanged. Ready pulse → Valid=0 next edge. Inputs then unchanged → no recapture; new pattern → captured after 6 edges.
- SEV_SELFCHECK_EN: A=0111, B=1111, AddSub=1, S=minus/8 → Mismatch=0, Ovr=1. Same with S=blank/0 → Mismatch=1.
- Reset pulse during HOLD → Valid=0, A/B/S=0000, ErrMask=000 after that edge; normal capture resumes afterwards.

Source files
------------

// File: rtl/sev_pkg.sv
// Shared constants for the seven-segment capture path: glyphs, FSM states, ErrMask bit positions.
package sev_pkg;

  // Active-low glyphs, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_HOLD,
    ST_WAIT_CHANGE
  } state_t;

  localparam int ERR_A = 2;
  localparam int ERR_B = 1;
  localparam int ERR_S = 0;

endpackage

// File: rtl/sev_pair_decode.sv
// Decodes one sign/digit pair of active-low glyphs into a signed 4-bit value plus an illegal flag.
module sev_pair_decode
  import sev_pkg::*;
(
  input  logic [6:0] left,
  input  logic [6:0] right,
  output logic [3:0] value,
  output logic       illegal
);

  logic [3:0] mag;
  logic       known;

  always_comb begin
    mag   = 4'd0;
    known = 1'b1;
    case (right)
      SEG_0:   mag = 4'd0;
      SEG_1:   mag = 4'd1;
      SEG_2:   mag = 4'd2;
      SEG_3:   mag = 4'd3;
      SEG_4:   mag = 4'd4;
      SEG_5:   mag = 4'd5;
      SEG_6:   mag = 4'd6;
      SEG_7:   mag = 4'd7;
      SEG_8:   mag = 4'd8;
      default: known = 1'b0;
    endcase
  end

  // Blank+8 and minus+0 have no 4-bit two's-complement meaning, so they are illegal
  always_comb begin
    value   = 4'd0;
    illegal = 1'b1;
    if (known) begin
      if (left == SEG_BLANK && mag != 4'd8) begin
        value   = mag;
        illegal = 1'b0;
      end else if (left == SEG_MINUS && mag != 4'd0) begin
        value   = ~mag + 4'd1;
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sev_seg_capture.sv
// Stability-filtered capture of the six display digits into A/B/S with Valid/Ready handshake.
// Optional arithmetic self-check of the displayed operation is enabled by SEV_SELFCHECK_EN.
module sev_seg_capture
  import sev_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [6:0] Hex5,
  input  logic [6:0] Hex4,
  input  logic [6:0] Hex3,
  input  logic [6:0] Hex2,
  input  logic [6:0] Hex1,
  input  logic [6:0] Hex0,
  input  logic       AddSub,
  input  logic       Ready,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] S,
  output logic       Valid,
  output logic       Err,
  output logic [2:0] ErrMask,
  output logic       Mismatch,
  output logic       Ovr
);

  // state          | meaning
  // ST_SETTLE      | waiting for Cnt to reach STABLE_CYCLES, then capture
  // ST_HOLD        | set presented with Valid=1, waiting for Ready
  // ST_WAIT_CHANGE | set consumed, waiting for HexQ to differ from Snap

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef SEV_SELFCHECK_EN
  localparam int HQ_W = 43;
`else
  localparam int HQ_W = 42;
`endif

  logic [HQ_W-1:0]  hex_in, hex_q, hex_prev, snap;
  logic [CNT_W-1:0] cnt;
  state_t           state, state_nxt;
  logic             do_capture, do_accept;
  logic [3:0]       dec_a, dec_b, dec_s;
  logic             ill_a, ill_b, ill_s;
  logic [2:0]       mask_c;
  logic [3:0]       a_r, b_r, s_r;
  logic [2:0]       mask_r;
  logic             valid_r, err_r;

`ifdef SEV_SELFCHECK_EN
  assign hex_in = {AddSub, Hex5, Hex4, Hex3, Hex2, Hex1, Hex0};
`else
  assign hex_in = {Hex5, Hex4, Hex3, Hex2, Hex1, Hex0};
  logic unused_addsub;
  assign unused_addsub = AddSub;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hex_q    <= '1;
      hex_prev <= '1;
      cnt      <= '0;
    end else begin
      hex_q    <= hex_in;
      hex_prev <= hex_q;
      if (hex_q != hex_prev)
        cnt <= '0;
      else if (cnt != CNT_W'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  sev_pair_decode u_dec_a (.left(hex_q[41:35]), .right(hex_q[34:28]), .value(dec_a), .illegal(ill_a));
  sev_pair_decode u_dec_b (.left(hex_q[27:21]), .right(hex_q[20:14]), .value(dec_b), .illegal(ill_b));
  sev_pair_decode u_dec_s (.left(hex_q[13:7]),  .right(hex_q[6:0]),   .value(dec_s), .illegal(ill_s));

  always_comb begin
    mask_c        = 3'b000;
    mask_c[ERR_A] = ill_a;
    mask_c[ERR_B] = ill_b;
    mask_c[ERR_S] = ill_s;
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      state <= ST_SETTLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_capture = 1'b0;
    do_accept  = 1'b0;
    case (state)
      ST_SETTLE: begin
        if (cnt == CNT_W'(STABLE_CYCLES)) begin
          do_capture = 1'b1;
          state_nxt  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (Ready) begin
          do_accept = 1'b1;
          state_nxt = ST_WAIT_CHANGE;
        end
      end
      ST_WAIT_CHANGE: begin
        if (hex_q != snap)
          state_nxt = ST_SETTLE;
      end
      default: state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      snap    <= '1;
      a_r     <= 4'd0;
      b_r     <= 4'd0;
      s_r     <= 4'd0;
      mask_r  <= 3'b000;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (do_capture) begin
      snap    <= hex_q;
      a_r     <= dec_a;
      b_r     <= dec_b;
      s_r     <= dec_s;
      mask_r  <= mask_c;
      err_r   <= |mask_c;
      valid_r <= 1'b1;
    end else if (do_accept) begin
      valid_r <= 1'b0;
    end
  end

`ifdef SEV_SELFCHECK_EN
  logic [3:0] b_op, e_sum;
  logic       mism_c, ovr_c, mism_r, ovr_r;

  // Subtract is A + ~B + 1; overflow when operand signs agree but the result sign differs
  always_comb begin
    b_op   = dec_b ^ {4{hex_q[42]}};
    e_sum  = dec_a + b_op + {3'b000, hex_q[42]};
    ovr_c  = (dec_a[3] == b_op[3]) && (e_sum[3] != dec_a[3]);
    mism_c = (e_sum != dec_s);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      mism_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else if (do_capture) begin
      mism_r <= mism_c & ~(|mask_c);
      ovr_r  <= ovr_c  & ~(|mask_c);
    end
  end

  assign Mismatch = mism_r;
  assign Ovr      = ovr_r;
`else
  assign Mismatch = 1'b0;
  assign Ovr      = 1'b0;
`endif

  assign A       = a_r;
  assign B       = b_r;
  assign S       = s_r;
  assign ErrMask = mask_r;
  assign Err     = err_r;
  assign Valid   = valid_r;

endmodule

// File: tb/tb_sev_seg_capture.sv
// Directed plus randomized bench for sev_seg_capture with a history-based reference model.
module tb_sev_seg_capture;

  localparam int N = 4;
  localparam logic [6:0] T_BLANK = 7'b1111111;
  localparam logic [6:0] T_MINUS = 7'b0111111;
`ifdef SEV_SELFCHECK_EN
  localparam logic [42:0] VMASK = {43{1'b1}};
`else
  localparam logic [42:0] VMASK = {1'b0, {42{1'b1}}};
`endif
  localparam int M_SETTLE = 0;
  localparam int M_HOLD   = 1;
  localparam int M_WAIT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ready, addsub;
  logic [6:0] h5, h4, h3, h2, h1, h0;
  logic [3:0] a_o, b_o, s_o;
  logic [2:0] mask_o;
  logic       valid_o, err_o, mism_o, ovr_o;

  sev_seg_capture #(.STABLE_CYCLES(N)) dut (
    .Clock(clk), .Reset(rst),
    .Hex5(h5), .Hex4(h4), .Hex3(h3), .Hex2(h2), .Hex1(h1), .Hex0(h0),
    .AddSub(addsub), .Ready(ready),
    .A(a_o), .B(b_o), .S(s_o),
    .Valid(valid_o), .Err(err_o), .ErrMask(mask_o),
    .Mismatch(mism_o), .Ovr(ovr_o)
  );

  int total = 0;
  int bad   = 0;

  // Model: sampled-input history indexed by edge number
  logic [42:0] hq [0:16383];
  int          e = 0;
  int          r = 0;
  int          mst = M_SETTLE;
  logic [42:0] msnap;
  logic [3:0]  ea = 0, eb = 0, es = 0;
  logic [2:0]  emask = 0;
  logic        ev = 0, eerr = 0, emis = 0, eovr = 0;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b1010101;
    endcase
  endfunction

  function automatic logic [13:0] enc(input int v);
    if (v < 0) return {T_MINUS, glyph(-v)};
    return {T_BLANK, glyph(v)};
  endfunction

  // Returns {illegal, value}
  function automatic logic [4:0] ref_dec(input logic [6:0] l, input logic [6:0] rt);
    int d;
    d = -1;
    for (int i = 0; i <= 8; i++)
      if (glyph(i) === rt) d = i;
    if (l === T_BLANK && d >= 0 && d <= 7) return {1'b0, 4'(d)};
    if (l === T_MINUS && d >= 1) return {1'b0, 4'(16 - d)};
    return 5'b10000;
  endfunction

  function automatic int sval(input logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  function automatic logic [42:0] cur_vec();
    return {addsub, h5, h4, h3, h2, h1, h0} & VMASK;
  endfunction

  task automatic set_vals(input int a, input int b, input int s);
    {h5, h4} = enc(a);
    {h3, h2} = enc(b);
    {h1, h0} = enc(s);
  endtask

  task automatic capture(input logic [42:0] v);
    logic [4:0] da, db, ds;
    int res;
    da = ref_dec(v[41:35], v[34:28]);
    db = ref_dec(v[27:21], v[20:14]);
    ds = ref_dec(v[13:7], v[6:0]);
    ea = da[3:0]; eb = db[3:0]; es = ds[3:0];
    emask = {da[4], db[4], ds[4]};
    eerr  = |emask;
    emis = 1'b0;
    eovr = 1'b0;
`ifdef SEV_SELFCHECK_EN
    res  = v[42] ? sval(ea) - sval(eb) : sval(ea) + sval(eb);
    eovr = (res > 7) || (res < -8);
    emis = (4'(res) != es);
    if (eerr) begin emis = 1'b0; eovr = 1'b0; end
`else
    res = 0;
`endif
  endtask

  task automatic model_edge();
    bit stable;
    e++;
    if (rst) begin
      r = e;
      hq[e] = VMASK; hq[e-1] = VMASK;
      mst = M_SETTLE; msnap = VMASK;
      ev = 0; ea = 0; eb = 0; es = 0; emask = 0; eerr = 0; emis = 0; eovr = 0;
      return;
    end
    hq[e] = cur_vec();
    case (mst)
      M_SETTLE: begin
        // N unchanged comparisons since reset must precede the capture edge
        stable = (e - N >= r + 1);
        if (stable)
          for (int j = 0; j <= N; j++)
            if (hq[e-2-j] !== hq[e-2]) stable = 0;
        if (stable) begin
          capture(hq[e-1]);
          msnap = hq[e-1];
          ev = 1;
          mst = M_HOLD;
        end
      end
      M_HOLD: if (ready) begin ev = 0; mst = M_WAIT; end
      default: if (hq[e-1] !== msnap) mst = M_SETTLE;
    endcase
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", name, got, exp, e);
    end
  endtask

  task automatic tick();
    if (e >= 16000) begin
      $display("FAIL edge_budget: observed=%0d expected<16000", e);
      $fatal(1, "edge budget exceeded");
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("valid",    {7'd0, valid_o}, {7'd0, ev});
    chk("a",        {4'd0, a_o},     {4'd0, ea});
    chk("b",        {4'd0, b_o},     {4'd0, eb});
    chk("s",        {4'd0, s_o},     {4'd0, es});
    chk("errmask",  {5'd0, mask_o},  {5'd0, emask});
    chk("err",      {7'd0, err_o},   {7'd0, eerr});
    chk("mismatch", {7'd0, mism_o},  {7'd0, emis});
    chk("ovr",      {7'd0, ovr_o},   {7'd0, eovr});
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (valid_o !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("valid_timeout", {7'd0, valid_o}, 8'd1);
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; ready = 1'b0; addsub = 1'b0;
    set_vals(0, 0, 0);
    tick(); tick();
    chk("reset_valid", {7'd0, valid_o}, 8'd0);
    chk("reset_mask",  {5'd0, mask_o},  8'd0);

    // Basic capture and latency
    rst = 1'b0;
    set_vals(3, -2, 1);
    tick();
    wait_valid(lat);
    chk("latency_basic", 8'(lat), 8'(N + 2));
    chk("basic_a", {4'd0, a_o}, 8'b0011);
    chk("basic_b", {4'd0, b_o}, 8'b1110);
    chk("basic_s", {4'd0, s_o}, 8'b0001);
    chk("basic_mask", {5'd0, mask_o}, 8'd0);
    repeat (3) tick();
    pulse_ready();
    chk("accept_valid", {7'd0, valid_o}, 8'd0);
    repeat (10) tick();
    chk("no_recapture", {7'd0, valid_o}, 8'd0);

    // Toggling S digit restarts the count each time
    for (int i = 0; i < 6; i++) begin
      set_vals(3, -2, (i % 2 == 0) ? 2 : 1);
      tick();
      if (i < 5) tick();
    end
    wait_valid(lat);
    chk("latency_toggle", 8'(lat), 8'(N + 2));
    pulse_ready();

    // Minus with zero is illegal
    set_vals(3, -2, 1);
    h1 = T_MINUS; h0 = glyph(0);
    tick();
    wait_valid(lat);
    chk("illegal_mask", {5'd0, mask_o}, 8'b001);
    chk("illegal_err",  {7'd0, err_o},  8'd1);
    chk("illegal_s",    {4'd0, s_o},    8'd0);
    pulse_ready();

    // HOLD ignores input activity until Ready
    set_vals(5, -7, 3);
    tick();
    wait_valid(lat);
    for (int i = 0; i < 20; i++) begin
      set_vals(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      tick();
    end
    set_vals(5, -7, 3);
    repeat (3) tick();
    chk("hold_valid", {7'd0, valid_o}, 8'd1);
    chk("hold_a",     {4'd0, a_o},     8'd5);
    pulse_ready();
    chk("hold_accept", {7'd0, valid_o}, 8'd0);
    repeat (10) tick();
    chk("hold_no_recapture", {7'd0, valid_o}, 8'd0);
    set_vals(-4, 6, 2);
    tick();
    wait_valid(lat);
    chk("latency_after_accept", 8'(lat), 8'(N + 2));
    pulse_ready();

    // Self-check cases: 7 - (-1) overflows to -8
    addsub = 1'b1;
    set_vals(7, -1, -8);
    tick();
    wait_valid(lat);
`ifdef SEV_SELFCHECK_EN
    chk("sc_mismatch0", {7'd0, mism_o}, 8'd0);
    chk("sc_ovr1",      {7'd0, ovr_o},  8'd1);
`endif
    pulse_ready();
    set_vals(7, -1, 0);
    tick();
    wait_valid(lat);
`ifdef SEV_SELFCHECK_EN
    chk("sc_mismatch1", {7'd0, mism_o}, 8'd1);
`endif

    // Reset during HOLD discards the pending set
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hold_valid", {7'd0, valid_o}, 8'd0);
    chk("rst_hold_a",     {4'd0, a_o},     8'd0);
    chk("rst_hold_mask",  {5'd0, mask_o},  8'd0);
    wait_valid(lat);
    chk("rst_recapture_a", {4'd0, a_o}, 8'd7);
    pulse_ready();

    // Randomized patterns, hold times, Ready activity and occasional resets
    for (int it = 0; it < 300; it++) begin
      set_vals(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      if ($urandom_range(0, 7) == 0) h5 = 7'($urandom);
      if ($urandom_range(0, 7) == 0) h2 = 7'($urandom);
      if ($urandom_range(0, 7) == 0) h1 = 7'($urandom);
      if ($urandom_range(0, 7) == 0) h0 = T_MINUS;
      addsub = 1'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < int'($urandom_range(1, 9)); c++) begin
        ready = ($urandom_range(0, 3) == 0);
        tick();
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
